// File: rtl/uart_adder_client_if.sv
// Byte-wide AXI-stream link used by uart_adder_client on both its transmit and receive sides.
interface uart_adder_client_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_adder_client.sv
// Host-side initiator for the UART byte-adder service: sends A then B, waits for the sum, checks it.
// Build macro UART_ADDER_CLIENT_RETRY_EN adds one automatic re-send after the first timeout.
module uart_adder_client #(
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int CNT_W          = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic [7:0]          i_op_a,
    input  logic [7:0]          i_op_b,
    uart_adder_client_if.master m_axis,
    uart_adder_client_if.slave  s_axis,
    output logic                o_busy,
    output logic                o_done,
    output logic [7:0]          o_result,
    output logic                o_match,
    output logic                o_timeout,
`ifdef UART_ADDER_CLIENT_RETRY_EN
    output logic                o_retried,
`endif
    output logic                o_stray_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_A,
        ST_SEND_B,
        ST_WAIT_RESP,
        ST_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [7:0]       r_a;
    logic [7:0]       r_b;
    logic [7:0]       r_exp;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_result;
    logic             r_match;
    logic             r_timeout;
    logic             r_stray;
    logic             r_s_tready;
    logic             w_s_fire;
    logic             w_m_fire;
    logic             w_cnt_term;
    logic             w_retry;
`ifdef UART_ADDER_CLIENT_RETRY_EN
    logic             r_retry_used;
`endif

    assign w_s_fire   = s_axis.tvalid && r_s_tready;
    assign w_m_fire   = m_axis.tvalid && m_axis.tready;
    assign w_cnt_term = (r_cnt == CNT_TERM);

`ifdef UART_ADDER_CLIENT_RETRY_EN
    assign w_retry = !r_retry_used;
`else
    assign w_retry = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:      if (i_start)  w_state_next = ST_SEND_A;
            ST_SEND_A:    if (w_m_fire) w_state_next = ST_SEND_B;
            ST_SEND_B:    if (w_m_fire) w_state_next = ST_WAIT_RESP;
            ST_WAIT_RESP: begin
                // A response on the terminal-count cycle takes priority over the timeout
                if (w_s_fire) begin
                    w_state_next = ST_DONE;
                end else if (w_cnt_term) begin
                    w_state_next = w_retry ? ST_SEND_A : ST_DONE;
                end
            end
            ST_DONE:      w_state_next = ST_IDLE;
            default:      w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= 8'h00;
            r_b          <= 8'h00;
            r_exp        <= 8'h00;
            r_cnt        <= '0;
            r_result     <= 8'h00;
            r_match      <= 1'b0;
            r_timeout    <= 1'b0;
            r_stray      <= 1'b0;
            r_s_tready   <= 1'b0;
`ifdef UART_ADDER_CLIENT_RETRY_EN
            r_retry_used <= 1'b0;
`endif
        end else begin
            r_s_tready <= 1'b1;
            unique case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_a     <= i_op_a;
                        r_b     <= i_op_b;
                        r_exp   <= i_op_a + i_op_b;
                        r_stray <= 1'b0;
`ifdef UART_ADDER_CLIENT_RETRY_EN
                        r_retry_used <= 1'b0;
`endif
                    end
                end
                ST_SEND_B: begin
                    if (w_m_fire) r_cnt <= '0;
                end
                ST_WAIT_RESP: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_s_fire) begin
                        r_result  <= s_axis.tdata;
                        r_match   <= (s_axis.tdata == r_exp);
                        r_timeout <= 1'b0;
                    end else if (w_cnt_term) begin
                        if (w_retry) begin
                            r_cnt <= '0;
`ifdef UART_ADDER_CLIENT_RETRY_EN
                            r_retry_used <= 1'b1;
`endif
                        end else begin
                            r_timeout <= 1'b1;
                            r_match   <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
            // Any byte outside the response window is swallowed and flagged
            if (w_s_fire && (r_state != ST_WAIT_RESP)) r_stray <= 1'b1;
        end
    end

    assign m_axis.tvalid = (r_state == ST_SEND_A) || (r_state == ST_SEND_B);
    assign m_axis.tdata  = (r_state == ST_SEND_B) ? r_b :
                           (r_state == ST_SEND_A) ? r_a : 8'h00;
    assign s_axis.tready = r_s_tready;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_done        = (r_state == ST_DONE);
    assign o_result      = r_result;
    assign o_match       = r_match;
    assign o_timeout     = r_timeout;
    assign o_stray_err   = r_stray;
`ifdef UART_ADDER_CLIENT_RETRY_EN
    assign o_retried     = r_retry_used;
`endif

endmodule

// File: tb/tb_uart_adder_client.sv
// Directed plus randomized bench for uart_adder_client, checked against a transaction-level model.
module tb_uart_adder_client;
    localparam int TO = 16;
`ifdef UART_ADDER_CLIENT_RETRY_EN
    localparam int N_ATT = 2;
`else
    localparam int N_ATT = 1;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] op_a  = 8'h00;
    logic [7:0] op_b  = 8'h00;
    logic       busy, done, match, timeout, stray;
    logic [7:0] result;
`ifdef UART_ADDER_CLIENT_RETRY_EN
    logic       retried;
`endif

    uart_adder_client_if m_if ();
    uart_adder_client_if s_if ();

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] sent_q[$];
    logic [7:0] exp_result = 8'h00;

    always #5 clk = ~clk;

    uart_adder_client #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (start),
        .i_op_a      (op_a),
        .i_op_b      (op_b),
        .m_axis      (m_if),
        .s_axis      (s_if),
        .o_busy      (busy),
        .o_done      (done),
        .o_result    (result),
        .o_match     (match),
        .o_timeout   (timeout),
`ifdef UART_ADDER_CLIENT_RETRY_EN
        .o_retried   (retried),
`endif
        .o_stray_err (stray)
    );

    // Record every byte that actually leaves on the transmit stream
    always @(posedge clk) begin
        if (rst_n && m_if.tvalid && m_if.tready) sent_q.push_back(m_if.tdata);
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operand byte: stall for 'stall' cycles (spamming ignored starts), then let it go
    task automatic send_byte(input string tag, input logic [7:0] data, input int stall);
        for (int c = 0; c < stall; c++) begin
            m_if.tready = 1'b0;
            start = 1'($urandom);
            op_a  = 8'($urandom);
            op_b  = 8'($urandom);
            check1({tag, "_tvalid_hold"}, m_if.tvalid, 1'b1);
            check8({tag, "_tdata_hold"}, m_if.tdata, data);
            step();
        end
        m_if.tready = 1'b1;
        check1({tag, "_tvalid"}, m_if.tvalid, 1'b1);
        check8({tag, "_tdata"}, m_if.tdata, data);
        step();
        m_if.tready = 1'b0;
        start = 1'b0;
    endtask

    // k1/k2: cycle (1..TO after the B transfer) on which the reply is offered; anything else = none
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input int st_a, input int st_b,
                           input int k1, input int k2, input logic [7:0] reply);
        logic [7:0] sum;
        int         kk;
        int         term;
        int         att_used;
        bit         timed_out;
        sum       = a + b;
        att_used  = 0;
        timed_out = 1'b0;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        step();
        start = 1'b0;
        op_a  = 8'($urandom);
        op_b  = 8'($urandom);
        check1("busy_after_start", busy, 1'b1);
        check1("stray_cleared", stray, 1'b0);
        for (int att = 0; att < N_ATT; att++) begin
            att_used++;
            send_byte("send_a", a, st_a);
            send_byte("send_b", b, st_b);
            kk        = (att == 0) ? k1 : k2;
            timed_out = !(kk >= 1 && kk <= TO);
            term      = timed_out ? TO : kk;
            for (int i = 1; i <= term; i++) begin
                s_if.tvalid = (i == kk);
                s_if.tdata  = (i == kk) ? reply : 8'($urandom);
                start       = 1'($urandom);
                check1("no_early_done", done, 1'b0);
                step();
                s_if.tvalid = 1'b0;
            end
            if (!(timed_out && att < N_ATT - 1)) break;
            check1("retry_resend", m_if.tvalid, 1'b1);
        end
        check1("done", done, 1'b1);
        if (!timed_out) exp_result = reply;
        check8("result", result, exp_result);
        check1("match", match, !timed_out && (reply == sum));
        check1("timeout", timeout, timed_out);
`ifdef UART_ADDER_CLIENT_RETRY_EN
        check1("retried", retried, att_used > 1);
`endif
        start = 1'($urandom);
        step();
        start = 1'b0;
        check1("done_one_cycle", done, 1'b0);
        check1("idle_not_busy", busy, 1'b0);
        check_int("sent_count", sent_q.size(), 2 * att_used);
        for (int j = 0; j < 2 * att_used; j++) begin
            check8("sent_byte", (j < sent_q.size()) ? sent_q[j] : 8'hxx, (j % 2 == 0) ? a : b);
        end
        sent_q.delete();
        $display("txn a=%02h b=%02h reply=%02h k1=%0d k2=%0d -> result=%02h match=%0b timeout=%0b",
                 a, b, reply, k1, k2, result, match, timeout);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] rr;
        m_if.tready = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = 8'h00;

        // Reset state
        #1;
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_m_tvalid", m_if.tvalid, 1'b0);
        check8("rst_m_tdata", m_if.tdata, 8'h00);
        check1("rst_s_tready", s_if.tready, 1'b0);
        check8("rst_result", result, 8'h00);
        check1("rst_match", match, 1'b0);
        check1("rst_timeout", timeout, 1'b0);
        check1("rst_stray", stray, 1'b0);
        repeat (2) step();
        rst_n = 1'b1;
        check1("tready_before_clock", s_if.tready, 1'b0);
        step();
        check1("tready_after_release", s_if.tready, 1'b1);
        $display("reset released");

        // Directed transactions
        run_txn(8'h12, 8'h34, 0, 0, 1, 1, 8'h46);
        run_txn(8'hF0, 8'h20, 0, 0, 1, 1, 8'h10);
        run_txn(8'hF0, 8'h20, 0, 0, 2, 2, 8'h11);
        run_txn(8'h5A, 8'hA5, 5, 3, 3, 3, 8'hFF);
        run_txn(8'h77, 8'h88, 0, 0, 0, 0, 8'h00);
        run_txn(8'h01, 8'h02, 1, 0, TO, TO, 8'h03);
        run_txn(8'h12, 8'h34, 0, 0, 0, 1, 8'h46);

        // Stray byte in IDLE is sticky until the next accepted start
        s_if.tvalid = 1'b1;
        s_if.tdata  = 8'h55;
        step();
        s_if.tvalid = 1'b0;
        check1("stray_set", stray, 1'b1);
        step();
        check1("stray_sticky", stray, 1'b1);
        check8("stray_no_result", result, exp_result);
        check1("stray_not_busy", busy, 1'b0);
        $display("stray byte 55 injected in idle -> stray_err=%0b", stray);
        run_txn(8'h80, 8'h80, 2, 2, 4, 4, 8'h00);

        // Randomized transactions
        for (int t = 0; t < 12; t++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rr = ($urandom_range(0, 2) != 0) ? 8'(ra + rb) : 8'($urandom);
            run_txn(ra, rb, $urandom_range(0, 5), $urandom_range(0, 5),
                    $urandom_range(0, TO + 2), $urandom_range(0, TO + 2), rr);
        end

        // Reset while waiting for the response
        op_a  = 8'h21;
        op_b  = 8'h43;
        start = 1'b1;
        step();
        start = 1'b0;
        m_if.tready = 1'b1;
        repeat (2) step();
        m_if.tready = 1'b0;
        repeat (3) step();
        check1("pre_reset_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check1("mid_rst_busy", busy, 1'b0);
        check1("mid_rst_done", done, 1'b0);
        check1("mid_rst_m_tvalid", m_if.tvalid, 1'b0);
        check8("mid_rst_m_tdata", m_if.tdata, 8'h00);
        check1("mid_rst_s_tready", s_if.tready, 1'b0);
        check8("mid_rst_result", result, 8'h00);
        check1("mid_rst_match", match, 1'b0);
        check1("mid_rst_timeout", timeout, 1'b0);
        check1("mid_rst_stray", stray, 1'b0);
        exp_result = 8'h00;
        repeat (2) step();
        rst_n = 1'b1;
        for (int c = 0; c < TO + 4; c++) begin
            step();
            check1("no_done_after_abort", done, 1'b0);
        end
        check1("abort_idle", busy, 1'b0);
        sent_q.delete();
        $display("reset asserted in wait_resp -> aborted, busy=%0b done=%0b", busy, done);
        run_txn(8'h12, 8'h34, 0, 0, 1, 1, 8'h46);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_adder_client.md
Name: uart_adder_client

Overview:
- Host-side initiator for the UART byte-adder service.
- Takes two operand bytes and sends them in order (A then B) on an AXI-stream master, which feeds the UART transmitter.
- Waits for the one-byte sum on an AXI-stream slave, which is fed by the UART receiver, then reports the result, a pass/fail against the locally computed sum, or a timeout.
- Used on the host/test FPGA to exercise the adder link end to end.

Parameters:
- TIMEOUT_CYCLES, 2000000, clk cycles allowed in WAIT_RESP before the transaction is declared timed out (must be >= 2).
- CNT_W, 32, width of the timeout counter (must hold TIMEOUT_CYCLES-1).

Ports:
- clk  input  1  single system clock, all logic rising-edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  request pulse; accepted only in IDLE.
- op_a  input  8  first operand, sampled on start acceptance.
- op_b  input  8  second operand, sampled on start acceptance.
- m_axis_tdata  output  8  operand byte to the UART transmitter.
- m_axis_tvalid  output  1  operand byte valid.
- m_axis_tready  input  1  transmitter accepts the byte.
- s_axis_tdata  input  8  byte from the UART receiver.
- s_axis_tvalid  input  1  received byte valid.
- s_axis_tready  output  1  always 1 out of reset; the receiver is never back-pressured.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at the end of every transaction.
- result  output  8  response byte captured in WAIT_RESP.
- match  output  1  result equals (op_a+op_b) mod 256; valid when done=1.
- timeout  output  1  the transaction ended without a response; valid when done=1.
- stray_err  output  1  sticky flag: a byte arrived outside WAIT_RESP.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0 except s_axis_tready; s_axis_tready is 0 during reset and 1 from the first clock after release.
  - Latched operands and the timeout counter are cleared.
  - Reset mid-transaction aborts immediately; no done pulse is issued.
- Handshake: a transfer occurs on a clk edge where tvalid&&tready. Once m_axis_tvalid is raised, it and m_axis_tdata stay stable until the transfer.
- States:
  - IDLE: if start=1, latch op_a/op_b into a_q/b_q, compute exp_q=(a_q+b_q) mod 256 (8-bit wrap, carry discarded), clear stray_err, go to SEND_A. In IDLE, start=0 does nothing.
  - SEND_A: m_axis_tvalid=1, m_axis_tdata=a_q. On transfer, go to SEND_B.
  - SEND_B: m_axis_tvalid=1, m_axis_tdata=b_q. On transfer, go to WAIT_RESP and clear the counter to 0. m_axis_tvalid stays continuously high across the SEND_A->SEND_B boundary; back-to-back bytes are allowed.
  - WAIT_RESP: m_axis_tvalid=0; the counter increments every cycle.
    - If s_axis_tvalid=1: result<=s_axis_tdata, match<=(s_axis_tdata==exp_q), timeout<=0, go to DONE.
    - Else if counter==TIMEOUT_CYCLES-1: timeout<=1, match<=0, result unchanged, go to DONE.
    - A response arriving on the same cycle as the timeout terminal count wins; timeout stays 0.
  - DONE: done=1 for exactly this cycle, then go to IDLE. result, match and timeout hold until the next start is accepted.
- Latency:
  - start accepted at edge N; m_axis_tvalid is high from cycle N+1.
  - Response accepted at edge M; done is high in cycle M+1.
  - Minimum start-to-done time is 4 cycles with tready=1 and an immediate response.
- start asserted while busy=1 is ignored; it is not queued.
- Stray bytes: any s_axis_tvalid in IDLE, SEND_A, SEND_B or DONE is consumed and discarded, and sets stray_err=1. Only reset or the next accepted start clears it.
- Only the first response byte in WAIT_RESP is used; any later bytes count as stray.

Optional Feature:
- Macro: UART_ADDER_CLIENT_RETRY_EN.
- Defined:
  - On timeout, the block re-sends A and B once (WAIT_RESP -> SEND_A) and reloads the counter.
  - Only a second timeout ends the transaction with done=1, timeout=1.
  - Adds output retried (1 bit), high with done when a retry occurred and cleared on the next start.
- Not defined:
  - A timeout goes directly to DONE.
  - The retried port does not exist.

Test Plan:
- Basic transaction: op_a=0x12, op_b=0x34, start; m_axis_tready=1; reply 0x46 -> bytes 0x12 then 0x34 on m_axis; done=1, result=0x46, match=1, timeout=0.
- Wrap and mismatch:
  - op_a=0xF0, op_b=0x20, reply 0x10 -> match=1 (8-bit wrap).
  - Same operands, reply 0x11 -> result=0x11, match=0.
- Back-pressure: m_axis_tready low for 5 cycles in SEND_A and 3 cycles in SEND_B -> tdata/tvalid held stable; bytes delivered in order; start pulses during busy are ignored.
- Timeout: TIMEOUT_CYCLES=16, no reply -> done exactly 16 cycles after the SEND_B transfer, timeout=1, match=0. A reply on the terminal cycle -> timeout=0.
- Stray byte and reset:
  - Byte 0x55 injected in IDLE -> stray_err=1; next start clears it.
  - reset=0 asserted in WAIT_RESP -> outputs 0 immediately, state IDLE, no done.
- With UART_ADDER_CLIENT_RETRY_EN: first attempt gets no reply, second attempt gets reply 0x46 -> operands sent twice; done with match=1, timeout=0, retried=1.
